// File: rtl/fifo_arb_pkg.sv
// Shared types, default constants and the round-robin pick helper for the
// FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 8;

  // The helper works on vectors sized for the largest supported arbiter;
  // callers zero-extend their request vector and pointer.
  localparam int RR_MAX_REQ  = 16;
  localparam int RR_MAX_ID_W = 4;

  // Index of the first set request bit at or after ptr, wrapping modulo
  // num_req. Returns 0 when no bit is set; callers qualify with |req.
  function automatic logic [RR_MAX_ID_W-1:0] rr_pick(
    input logic [RR_MAX_REQ-1:0]  req,
    input logic [RR_MAX_ID_W-1:0] ptr,
    input int                     num_req
  );
    logic [RR_MAX_ID_W-1:0] win;
    logic                   found;
    int                     idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      if (k < num_req) begin
        idx = int'(ptr) + k;
        if (idx >= num_req) idx = idx - num_req;
        if (!found && req[idx[RR_MAX_ID_W-1:0]]) begin
          found = 1'b1;
          win   = idx[RR_MAX_ID_W-1:0];
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: first asserted request at or after the
// start pointer, wrapping around the request vector.
module rr_priority_sel
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_found
);

  logic [RR_MAX_REQ-1:0]  w_req_ext;
  logic [RR_MAX_ID_W-1:0] w_ptr_ext;
  logic [RR_MAX_ID_W-1:0] w_pick;
  logic                   w_unused_pick;

  // Zero-extend the request vector and pointer to the helper's fixed width.
  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_REQ-1:0] = i_req;
    w_ptr_ext              = '0;
    w_ptr_ext[ID_W-1:0]    = i_ptr;
  end

  assign w_pick        = rr_pick(w_req_ext, w_ptr_ext, NUM_REQ);
  assign o_idx         = w_pick[ID_W-1:0];
  assign o_found       = |i_req;
  assign w_unused_pick = ^w_pick;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single async-FIFO write port among
// NUM_REQ write-domain requesters. A grant lasts until the requester's last
// beat or MAX_BURST beats, and one IDLE cycle separates consecutive grants.
//
// Handshake: a beat moves when req_valid[g] & req_ready[g] are both high on
// a rising clk edge. req_ready[g] depends only on the grant and fifo_full,
// never on req_valid. Once a requester raises req_valid it must hold it,
// together with its data and last, until the beat is accepted.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output arb_state_t                o_dbg_state
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant_id;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [ID_W-1:0]   w_win;
  logic              w_found;
  logic              w_g_valid;
  logic              w_g_last;
  logic [DATA_W-1:0] w_g_data;
  logic              w_xfer;
  logic              w_burst_end;

  rr_priority_sel #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_sel (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  assign w_g_valid   = req_valid[r_grant_id];
  assign w_g_last    = req_last[r_grant_id];
  assign w_g_data    = req_data[r_grant_id*DATA_W +: DATA_W];
  assign w_xfer      = (r_state == GRANT) && w_g_valid && !fifo_full;
  assign w_burst_end = (r_beat_cnt == CNT_W'(MAX_BURST - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and the combinational write-port outputs.
  always_comb begin
    w_state_nxt  = r_state;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    case (r_state)
      IDLE: begin
        if (w_found) w_state_nxt = GRANT;
      end
      GRANT: begin
        req_ready[r_grant_id] = !fifo_full;
        fifo_wr_en            = w_xfer;
        if (w_xfer) fifo_wr_data = w_g_data;
        if (w_xfer && (w_g_last || w_burst_end)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: latch the winner and advance the pointer past it;
  // count accepted beats within the grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_grant_id <= w_win;
        r_rr_ptr   <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        r_beat_cnt <= '0;
      end
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign grant_valid = (r_state == GRANT);
  assign grant_id    = r_grant_id;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester beat sources, a write
// scoreboard with an expected queue, and a handshake-stability monitor.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int MB  = 8;
  localparam int IDW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             grant_valid;
  logic [IDW-1:0]   grant_id;
  arb_state_t       dbg_state;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MB),
    .ID_W      (IDW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [DW-1:0] exp_q[$];
  int            n_writes = 0;
  int            n_extra  = 0;
  logic [NR-1:0] acc_r    = '0;
  logic [NR-1:0] pend     = '0;
  logic [8:0]    prev_beat[NR];

  always @(negedge clk) begin
    acc_r = req_valid & req_ready;
    if (!reset_n) begin
      pend = '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          check("hs_valid_held", 32'(req_valid[i]), 32'd1);
          check("hs_beat_stable", 32'({req_last[i], req_data[i*DW +: DW]}), 32'(prev_beat[i]));
        end
        pend[i]      = req_valid[i] & ~req_ready[i];
        prev_beat[i] = {req_last[i], req_data[i*DW +: DW]};
      end
      if (fifo_wr_en) begin
        n_writes++;
        check("wr_not_full", 32'(fifo_full), 32'd0);
        check("wr_in_grant", 32'(grant_valid), 32'd1);
        if (exp_q.size() > 0) check("wr_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
        else n_extra++;
      end
    end
  end

  // ---------------- driver ----------------
  logic [8:0]    src_mem[NR][32];
  int            src_cnt[NR];
  int            src_rd[NR];
  logic [NR-1:0] hold;
  int            order[5] = '{0, 1, 2, 3, 0};

  task automatic present();
    for (int i = 0; i < NR; i++) begin
      if (src_rd[i] < src_cnt[i] && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = src_mem[i][src_rd[i]][8];
        req_data[i*DW +: DW]  = src_mem[i][src_rd[i]][7:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_cnt[i] = 0;
      src_rd[i]  = 0;
    end
    hold  = '0;
    acc_r = '0;
  endtask

  task automatic load(input int r, input logic last, input logic [7:0] d, input logic expect_wr);
    src_mem[r][src_cnt[r]] = {last, d};
    src_cnt[r]++;
    if (expect_wr) exp_q.push_back(d);
  endtask

  // Advance one clock; retire beats accepted on the edge and present the next.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc_r[i]) src_rd[i]++;
    present();
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    n_writes = 0;
  endtask

  task automatic end_test(input string tag, input int exp_writes);
    check({tag, "_writes"}, 32'(n_writes), 32'(exp_writes));
    check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset(input string tag);
    clear_src();
    present();
    reset_n = 1'b0;
    #1;
    check_idle_outputs(tag);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    do_reset("rst0");

    // T1: requester 1 sends A1, A2, A3(last).
    start_test();
    load(1, 1'b0, 8'hA1, 1'b1);
    load(1, 1'b0, 8'hA2, 1'b1);
    load(1, 1'b1, 8'hA3, 1'b1);
    present();
    #1;
    check("t1_c0_grant_valid", 32'(grant_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      #1;
      if (k <= 3) begin
        check("t1_grant_valid", 32'(grant_valid), 32'd1);
        check("t1_grant_id", 32'(grant_id), 32'd1);
        check("t1_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t1_wr_data", 32'(fifo_wr_data), 32'(8'hA0 + k));
        check("t1_req_ready", 32'(req_ready), 32'h2);
      end else begin
        check("t1_end_grant_valid", 32'(grant_valid), 32'd0);
        check("t1_end_wr_en", 32'(fifo_wr_en), 32'd0);
      end
    end
    end_test("t1", 3);

    // T2: all four requesters valid from reset, single-beat packets.
    do_reset("rst1");
    start_test();
    for (int i = 0; i < NR; i++) load(i, 1'b1, 8'(8'h10 + i), 1'b1);
    load(0, 1'b1, 8'h20, 1'b1);
    present();
    #1;
    check("t2_c0_grant_valid", 32'(grant_valid), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      cycle();
      #1;
      if (k % 2 == 1) begin
        check("t2_grant_valid", 32'(grant_valid), 32'd1);
        check("t2_grant_id", 32'(grant_id), 32'(order[(k-1)/2]));
        check("t2_wr_en", 32'(fifo_wr_en), 32'd1);
      end else begin
        check("t2_bubble_grant_valid", 32'(grant_valid), 32'd0);
        check("t2_bubble_wr_en", 32'(fifo_wr_en), 32'd0);
      end
    end
    end_test("t2", 5);

    // T3: requester 2 streams 20 beats with no last; bursts of 8, 8, 4.
    start_test();
    for (int j = 0; j < 20; j++) load(2, 1'b0, 8'(8'h40 + j), 1'b1);
    present();
    #1;
    check("t3_c0_grant_valid", 32'(grant_valid), 32'd0);
    for (int k = 1; k <= 23; k++) begin
      cycle();
      #1;
      check("t3_grant_valid", 32'(grant_valid), 32'((k == 9 || k == 18) ? 0 : 1));
      check("t3_wr_en", 32'(fifo_wr_en), 32'((k == 9 || k == 18 || k >= 23) ? 0 : 1));
      if (grant_valid) check("t3_grant_id", 32'(grant_id), 32'd2);
    end
    end_test("t3", 20);

    // T4: fifo_full held for 5 cycles while beat 2 of 4 is presented.
    do_reset("rst2");
    start_test();
    load(1, 1'b0, 8'h51, 1'b1);
    load(1, 1'b0, 8'h52, 1'b1);
    load(1, 1'b0, 8'h53, 1'b1);
    load(1, 1'b1, 8'h54, 1'b1);
    present();
    #1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      fifo_full = (k >= 2 && k <= 6);
      #1;
      if (k >= 2 && k <= 6) begin
        check("t4_full_req_ready", 32'(req_ready), 32'd0);
        check("t4_full_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t4_full_wr_data", 32'(fifo_wr_data), 32'd0);
        check("t4_full_grant_valid", 32'(grant_valid), 32'd1);
      end else if (k <= 9) begin
        check("t4_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t4_req_ready", 32'(req_ready), 32'h2);
      end else begin
        check("t4_end_grant_valid", 32'(grant_valid), 32'd0);
      end
    end
    fifo_full = 1'b0;
    end_test("t4", 4);

    // T5: requester 3 stalls for 4 cycles mid-packet while requester 0 waits.
    start_test();
    load(3, 1'b0, 8'h61, 1'b1);
    load(3, 1'b0, 8'h62, 1'b1);
    load(3, 1'b1, 8'h63, 1'b1);
    load(0, 1'b1, 8'h71, 1'b1);
    present();
    #1;
    check("t5_c0_grant_valid", 32'(grant_valid), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      hold[3] = (k >= 2 && k <= 5);
      cycle();
      #1;
      if (k <= 7) begin
        check("t5_grant_valid", 32'(grant_valid), 32'd1);
        check("t5_grant_id", 32'(grant_id), 32'd3);
        check("t5_wr_en", 32'(fifo_wr_en), 32'((k >= 2 && k <= 5) ? 0 : 1));
      end else if (k == 9) begin
        check("t5_r0_grant_valid", 32'(grant_valid), 32'd1);
        check("t5_r0_grant_id", 32'(grant_id), 32'd0);
        check("t5_r0_wr_en", 32'(fifo_wr_en), 32'd1);
      end else begin
        check("t5_bubble_grant_valid", 32'(grant_valid), 32'd0);
      end
    end
    end_test("t5", 4);

    // T6: reset pulsed while beat 3 of a burst is on the write port.
    start_test();
    load(2, 1'b0, 8'h81, 1'b1);
    load(2, 1'b0, 8'h82, 1'b1);
    load(2, 1'b0, 8'h83, 1'b0);
    load(2, 1'b1, 8'h84, 1'b0);
    present();
    #1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      #1;
      check("t6_wr_en", 32'(fifo_wr_en), 32'd1);
      check("t6_grant_id", 32'(grant_id), 32'd2);
    end
    check("t6_beat3_data", 32'(fifo_wr_data), 32'h83);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("t6_async_rst");
    clear_src();
    present();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    end_test("t6a", 2);

    // After reset the pointer restarts at 0, so requester 0 beats requester 3.
    start_test();
    load(0, 1'b1, 8'h91, 1'b1);
    load(3, 1'b1, 8'hA9, 1'b1);
    present();
    #1;
    check("t6b_c0_grant_valid", 32'(grant_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      #1;
      if (k == 1 || k == 3) begin
        check("t6b_grant_valid", 32'(grant_valid), 32'd1);
        check("t6b_grant_id", 32'(grant_id), 32'((k == 1) ? 0 : 3));
        check("t6b_wr_en", 32'(fifo_wr_en), 32'd1);
      end else begin
        check("t6b_bubble_grant_valid", 32'(grant_valid), 32'd0);
      end
    end
    end_test("t6b", 2);

    check("extra_writes", 32'(n_extra), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
